// File: rtl/rx_ber_checker.sv
// -----------------------------------------------------------------------------
// rx_ber_checker
//
// Receive-side bit-error-rate checker for the PRBS9 + BPSK + RC transmit
// chain. The oversampled filter output is decimated by OS at a selectable
// phase, sliced to bits, and compared against a local PRBS9 reference that
// self-synchronises to the received stream. Once locked, compared bits and
// bit errors are accumulated.
//
// Optional feature (macro RX_BER_RELOCK_EN): while locked, a sliding window
// of RELOCK_WIN bits counts errors. RELOCK_THR errors inside one window
// force a return to SEED. Without the macro, lock is held until the enable
// drops or reset.
//
// Ports:
//   clock        system clock
//   i_reset      asynchronous reset, active-low
//   i_enable     RX enable; low forces IDLE and freezes the counters
//   i_phase      sampling offset within a symbol (0..OS-1)
//   i_data       signed RC filter output, one sample per clock
//   o_rx_bit     last sliced bit
//   o_locked     local reference aligned to the received stream
//   o_is_zero    locked and no error seen since lock
//   o_err_count  bit errors since lock (saturating)
//   o_bit_count  compared bits since lock (saturating)
//   o_state      FSM state for debug (0 IDLE, 1 SEED, 2 VERIFY, 3 LOCKED)
// -----------------------------------------------------------------------------
module rx_ber_checker #(
  parameter int OS         = 4,
  parameter int NB_DATA    = 8,
  parameter int NB_CNT     = 32,
  parameter int VERIFY_LEN = 16,
  parameter int RELOCK_WIN = 64,
  parameter int RELOCK_THR = 8
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [$clog2(OS)-1:0]     i_phase,
  input  logic signed [NB_DATA-1:0] i_data,
  output logic                      o_rx_bit,
  output logic                      o_locked,
  output logic                      o_is_zero,
  output logic [NB_CNT-1:0]         o_err_count,
  output logic [NB_CNT-1:0]         o_bit_count,
  output logic [1:0]                o_state
);

  localparam int PW = $clog2(OS);
  localparam int RW = $clog2(VERIFY_LEN + 1);
  localparam logic signed [NB_DATA-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     phase_cnt;
  logic [8:0]        s, s_n;        // s[0] newest bit, s[8] oldest
  logic [3:0]        fill, fill_n;
  logic [RW-1:0]     run, run_n;
  logic [NB_CNT-1:0] err_cnt, err_n;
  logic [NB_CNT-1:0] bit_cnt, bit_n;
  logic              rx_bit_q;
  logic              is_zero_q;
  logic              clr;

  logic strobe;
  logic rx;
  logic pred;
  logic bit_sat;
  logic err_sat;

`ifdef RX_BER_RELOCK_EN
  localparam int WBW = $clog2(RELOCK_WIN);
  localparam int TW  = $clog2(RELOCK_THR + 1);
  logic [WBW-1:0] win_bits, win_bits_n;
  logic [TW-1:0]  win_errs, win_errs_n;
`endif

  // Decimation strobe: one sample per symbol at the selected phase.
  assign strobe  = i_enable && (phase_cnt == i_phase);
  assign rx      = (i_data >= ZERO);
  // b[n] = b[n-5] ^ b[n-9]
  assign pred    = s[8] ^ s[4];
  assign bit_sat = &bit_cnt;
  assign err_sat = &err_cnt;

  always_comb begin
    state_n = state;
    s_n     = s;
    fill_n  = fill;
    run_n   = run;
    err_n   = err_cnt;
    bit_n   = bit_cnt;
    clr     = 1'b0;
`ifdef RX_BER_RELOCK_EN
    win_bits_n = win_bits;
    win_errs_n = win_errs;
`endif

    case (state)
      IDLE: begin
        state_n = SEED;
        fill_n  = 4'd0;
        clr     = 1'b1;
      end
      SEED: begin
        if (strobe) begin
          s_n = {s[7:0], rx};
          if (fill == 4'd8) begin
            state_n = VERIFY;
            fill_n  = 4'd0;
            run_n   = '0;
          end else begin
            fill_n = fill + 4'd1;
          end
        end
      end
      VERIFY: begin
        if (strobe) begin
          if (rx == pred) begin
            s_n = {s[7:0], rx};
            if (run == RW'(VERIFY_LEN - 1)) begin
              state_n = LOCKED;
              run_n   = '0;
              clr     = 1'b1;
            end else begin
              run_n = run + RW'(1);
            end
          end else begin
            state_n = SEED;
            fill_n  = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (strobe) begin
          // Free-running reference: never re-seeded from the line once locked.
          s_n = {s[7:0], pred};
          // Saturated bit counter freezes both counters.
          if (!bit_sat) begin
            bit_n = bit_cnt + NB_CNT'(1);
            if ((rx != pred) && !err_sat) err_n = err_cnt + NB_CNT'(1);
          end
`ifdef RX_BER_RELOCK_EN
          if ((int'(win_errs) + int'(rx != pred)) >= RELOCK_THR) begin
            state_n = SEED;
            fill_n  = 4'd0;
            clr     = 1'b1;
          end else if (win_bits == WBW'(RELOCK_WIN - 1)) begin
            win_bits_n = '0;
            win_errs_n = '0;
          end else begin
            win_bits_n = win_bits + WBW'(1);
            win_errs_n = win_errs + TW'(rx != pred);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // Disable wins over any strobe in the same cycle; everything holds.
    if (!i_enable) begin
      state_n = IDLE;
      s_n     = s;
      fill_n  = fill;
      run_n   = run;
      err_n   = err_cnt;
      bit_n   = bit_cnt;
      clr     = 1'b0;
`ifdef RX_BER_RELOCK_EN
      win_bits_n = win_bits;
      win_errs_n = win_errs;
`endif
    end

    if (clr) begin
      err_n = '0;
      bit_n = '0;
`ifdef RX_BER_RELOCK_EN
      win_bits_n = '0;
      win_errs_n = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      s         <= '0;
      fill      <= '0;
      run       <= '0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
      rx_bit_q  <= 1'b0;
      is_zero_q <= 1'b0;
`ifdef RX_BER_RELOCK_EN
      win_bits  <= '0;
      win_errs  <= '0;
`endif
    end else begin
      state   <= state_n;
      s       <= s_n;
      fill    <= fill_n;
      run     <= run_n;
      err_cnt <= err_n;
      bit_cnt <= bit_n;
      // OS is a power of two, so the natural wrap gives mod OS.
      if (i_enable) phase_cnt <= phase_cnt + PW'(1);
      if (strobe)   rx_bit_q  <= rx;
      is_zero_q <= (state_n == LOCKED) && (err_n == '0);
`ifdef RX_BER_RELOCK_EN
      win_bits <= win_bits_n;
      win_errs <= win_errs_n;
`endif
    end
  end

  assign o_rx_bit    = rx_bit_q;
  assign o_locked    = (state == LOCKED);
  assign o_is_zero   = is_zero_q;
  assign o_err_count = err_cnt;
  assign o_bit_count = bit_cnt;
  assign o_state     = state;

endmodule

// File: tb/tb_rx_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_ber_checker
//
// Directed bench for rx_ber_checker. A local PRBS9 source (seed 0x1AA)
// drives +64/-64 on symbol phase 2 and the opposite sign on the other
// phases. A second instance with 4-bit counters exercises saturation.
// -----------------------------------------------------------------------------
module tb_rx_ber_checker;

  localparam int OS = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEED   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              i_reset;
  logic              i_enable;
  logic [1:0]        i_phase;
  logic signed [7:0] i_data;

  logic        o_rx_bit, o_locked, o_is_zero;
  logic [31:0] o_err_count, o_bit_count;
  logic [1:0]  o_state;

  logic        s_rx_bit, s_locked, s_is_zero;
  logic [3:0]  s_err_count, s_bit_count;
  logic [1:0]  s_state;

  rx_ber_checker #(.OS(OS), .NB_DATA(8), .NB_CNT(32)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_phase     (i_phase),
    .i_data      (i_data),
    .o_rx_bit    (o_rx_bit),
    .o_locked    (o_locked),
    .o_is_zero   (o_is_zero),
    .o_err_count (o_err_count),
    .o_bit_count (o_bit_count),
    .o_state     (o_state)
  );

  rx_ber_checker #(.OS(OS), .NB_DATA(8), .NB_CNT(4)) dut_sat (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_phase     (i_phase),
    .i_data      (i_data),
    .o_rx_bit    (s_rx_bit),
    .o_locked    (s_locked),
    .o_is_zero   (s_is_zero),
    .o_err_count (s_err_count),
    .o_bit_count (s_bit_count),
    .o_state     (s_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [0:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- stimulus model
  logic [8:0] h;
  logic [1:0] ph;
  logic       cur_bit;
  int         sym_idx;
  int         flip_lo, flip_hi;
  int         n_strobe;
  int         n_ticks;
  logic       ever_locked;
  logic       saw_verify;

  function automatic logic prbs_next();
    logic b;
    b = h[8] ^ h[4];
    h = {h[7:0], b};
    return b;
  endfunction

  // One clock: drive the sample, clock it, check the sliced bit, advance phase.
  task automatic tick();
    logic sb;
    logic stb;
    sb = cur_bit ^ ((sym_idx >= flip_lo) && (sym_idx <= flip_hi));
    if (ph == 2'd2) i_data = sb ? 8'sd64 : -8'sd64;
    else            i_data = sb ? -8'sd64 : 8'sd64;
    stb = i_enable && (ph == i_phase);
    if (stb) exp_q.push_back(i_data >= 0);
    @(posedge clock);
    #1;
    n_ticks++;
    if (o_locked) ever_locked = 1'b1;
    if (o_state == ST_VERIFY) saw_verify = 1'b1;
    if (stb) begin
      n_strobe++;
      check_eq("rx_bit", {31'd0, o_rx_bit}, {31'd0, exp_q.pop_front()});
    end
    if (i_enable) begin
      ph = ph + 2'd1;
      if (ph == 2'd0) begin
        sym_idx++;
        cur_bit = prbs_next();
      end
    end
  endtask

  task automatic run_strobes(input int n);
    int   target;
    logic timed_out;
    target = n_strobe + n;
    for (int k = 0; k < n * OS + 8; k++) begin
      if (n_strobe >= target) break;
      tick();
    end
    timed_out = (n_strobe < target);
    check_eq("strobe_timeout", {31'd0, timed_out}, 32'd0);
  endtask

  task automatic do_reset();
    i_reset  = 1'b0;
    i_enable = 1'b0;
    ph       = 2'd0;
    h        = 9'h1AA;
    sym_idx  = 0;
    cur_bit  = prbs_next();
    flip_lo  = -1;
    flip_hi  = -1;
    exp_q.delete();
    repeat (3) tick();
    i_reset     = 1'b1;
    tick();
    n_strobe    = 0;
    n_ticks     = 0;
    ever_locked = 1'b0;
    saw_verify  = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  initial begin
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_phase  = 2'd2;
    i_data   = '0;

    // Reset mid-run: outputs clear asynchronously, then IDLE while disabled.
    do_reset();
    i_enable = 1'b1;
    run_strobes(30);
    check_eq("rst_pre_locked", {31'd0, o_locked}, 32'd1);
    i_reset = 1'b0;
    #1;
    check_eq("rst_locked",  {31'd0, o_locked},  32'd0);
    check_eq("rst_is_zero", {31'd0, o_is_zero}, 32'd0);
    check_eq("rst_rx_bit",  {31'd0, o_rx_bit},  32'd0);
    check_eq("rst_err",     o_err_count,        32'd0);
    check_eq("rst_bits",    o_bit_count,        32'd0);
    check_eq("rst_state",   {30'd0, o_state},   {30'd0, ST_IDLE});
    i_enable = 1'b0;
    #2;
    i_reset = 1'b1;
    repeat (20) tick();
    check_eq("idle_hold_state",  {30'd0, o_state}, {30'd0, ST_IDLE});
    check_eq("idle_hold_locked", {31'd0, o_locked}, 32'd0);

    // Clean stream, correct phase.
    do_reset();
    i_phase  = 2'd2;
    i_enable = 1'b1;
    run_strobes(24);
    check_eq("clean_prelock", {31'd0, o_locked}, 32'd0);
    run_strobes(1);
    check_eq("clean_locked",     {31'd0, o_locked},  32'd1);
    check_eq("clean_lock_clks",  {31'd0, n_ticks <= 100}, 32'd1);
    check_eq("clean_is_zero",    {31'd0, o_is_zero}, 32'd1);
    check_eq("clean_state",      {30'd0, o_state},   {30'd0, ST_LOCKED});
    check_eq("clean_bits0",      o_bit_count,        32'd0);
    run_strobes(1000);
    check_eq("clean_err1000",    o_err_count,        32'd0);
    check_eq("clean_bits1000",   o_bit_count,        32'd1000);
    check_eq("clean_is_zero1000",{31'd0, o_is_zero}, 32'd1);
    check_eq("sat_bits",         {28'd0, s_bit_count}, 32'd15);
    check_eq("sat_err",          {28'd0, s_err_count}, 32'd0);

    // One flipped symbol after lock.
    flip_lo = n_strobe;
    flip_hi = n_strobe;
    run_strobes(10);
    check_eq("flip_err",     o_err_count,        32'd1);
    check_eq("flip_bits",    o_bit_count,        32'd1010);
    check_eq("flip_is_zero", {31'd0, o_is_zero}, 32'd0);
    check_eq("flip_locked",  {31'd0, o_locked},  32'd1);
    check_eq("sat_frozen_err",  {28'd0, s_err_count}, 32'd0);
    check_eq("sat_frozen_bits", {28'd0, s_bit_count}, 32'd15);

    // Wrong sampling phase sees the inverted stream and never locks.
    do_reset();
    i_phase  = 2'd0;
    i_enable = 1'b1;
    run_strobes(300);
    check_eq("wrong_never_locked", {31'd0, ever_locked}, 32'd0);
    check_eq("wrong_saw_verify",   {31'd0, saw_verify},  32'd1);
    check_eq("wrong_is_zero",      {31'd0, o_is_zero},   32'd0);

    // Error during VERIFY at run count 10 (strobe 20).
    do_reset();
    i_phase  = 2'd2;
    i_enable = 1'b1;
    flip_lo  = 19;
    flip_hi  = 19;
    run_strobes(19);
    check_eq("verr_in_verify", {30'd0, o_state}, {30'd0, ST_VERIFY});
    run_strobes(1);
    check_eq("verr_back_seed", {30'd0, o_state}, {30'd0, ST_SEED});
    run_strobes(24);
    check_eq("verr_prelock",   {31'd0, o_locked}, 32'd0);
    run_strobes(1);
    check_eq("verr_locked",    {31'd0, o_locked},  32'd1);
    check_eq("verr_is_zero",   {31'd0, o_is_zero}, 32'd1);

    // Eight errors inside one window after lock.
    do_reset();
    i_phase  = 2'd2;
    i_enable = 1'b1;
    run_strobes(25);
    check_eq("burst_locked", {31'd0, o_locked}, 32'd1);
    run_strobes(5);
    flip_lo = n_strobe;
    flip_hi = n_strobe + 7;
    run_strobes(7);
    check_eq("burst_err7",    o_err_count,       32'd7);
    check_eq("burst_locked7", {31'd0, o_locked}, 32'd1);
    run_strobes(1);
`ifdef RX_BER_RELOCK_EN
    check_eq("relock_drop",  {31'd0, o_locked}, 32'd0);
    check_eq("relock_err",   o_err_count,       32'd0);
    check_eq("relock_bits",  o_bit_count,       32'd0);
    check_eq("relock_state", {30'd0, o_state},  {30'd0, ST_SEED});
    run_strobes(24);
    check_eq("relock_prelock", {31'd0, o_locked}, 32'd0);
    run_strobes(1);
    check_eq("relock_locked",  {31'd0, o_locked}, 32'd1);
    check_eq("relock_is_zero", {31'd0, o_is_zero}, 32'd1);
`else
    check_eq("burst_err8",    o_err_count,        32'd8);
    check_eq("burst_bits",    o_bit_count,        32'd13);
    check_eq("burst_held",    {31'd0, o_locked},  32'd1);
    check_eq("burst_is_zero", {31'd0, o_is_zero}, 32'd0);
    check_eq("sat_burst_err",  {28'd0, s_err_count}, 32'd8);
    check_eq("sat_burst_bits", {28'd0, s_bit_count}, 32'd13);
`endif

    // Enable drop holds the counters and returns to IDLE.
    i_enable = 1'b0;
    tick();
    check_eq("disable_state", {30'd0, o_state}, {30'd0, ST_IDLE});

    // ---------------------------------------------------------------- report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ber_checker.md
Name: rx_ber_checker

Overview:
- Receive-side counterpart of the PRBS9 + BPSK + RC transmit chain.
- Consumes the oversampled filter output and decimates by OS at a selectable sampling phase, then slices BPSK symbols to bits.
- Self-synchronises a local PRBS9 reference to the received stream and counts bit errors once locked.
- Drives the "BER = 0" LED and exposes error and bit counters for debug.

Parameters:
OS, 4, oversampling factor; samples per symbol, power of 2
NB_DATA, 8, width of signed input sample
NB_CNT, 32, width of error and bit counters
VERIFY_LEN, 16, consecutive error-free bits required to declare lock
RELOCK_WIN, 64, window length in bits for loss-of-lock detection (optional feature)
RELOCK_THR, 8, errors within one window that force relock (optional feature)

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous reset, active-low
i_enable  in  1  RX enable, from switch 1
i_phase  in  log2(OS)  sampling offset within a symbol, from switches 3:2
i_data  in  NB_DATA  signed two's-complement RC filter output, one sample per clock while enabled
o_rx_bit  out  1  last sliced bit
o_locked  out  1  reference PRBS aligned
o_is_zero  out  1  o_locked AND o_err_count == 0
o_err_count  out  NB_CNT  accumulated bit errors since lock
o_bit_count  out  NB_CNT  accumulated compared bits since lock

Behaviour:
Reset:
- i_reset low asynchronously clears all state.
- State = IDLE, phase counter = 0, LFSR = 0, all outputs 0.

Decimation:
- The phase counter is mod OS. It increments every clock while i_enable = 1 and holds otherwise.
- A strobe fires in a cycle where the counter equals i_phase. i_phase is sampled live; changing it mid-run simply moves the strobe.
- On a strobe, the bit is 1 if i_data >= 0 (MSB = 0), else 0.
- The sliced bit is registered into o_rx_bit on the same edge. All other registers also update on that edge, so there is 1 clock of latency from the strobe.

PRBS contract:
- Recurrence b[n] = b[n-5] XOR b[n-9], the same polynomial as the transmit prbs9.
- Local register s[8:0] holds history: s[0] = newest, s[8] = oldest.
- predicted = s[8] XOR s[4].

FSM, advancing only on strobes except where noted:
- IDLE: entered whenever i_enable = 0, regardless of state. Counters hold; o_locked = 0. On i_enable = 1 go to SEED and clear counters and the fill count.
- SEED: shift the received bit in, s <= {s[7:0], rx}. After 9 strobes go to VERIFY with the run count = 0.
- VERIFY: compare rx against predicted.
  - Match: s <= {s[7:0], rx} and increment the run count.
  - Mismatch: go to SEED, refill all 9 bits.
  - The run count reaching VERIFY_LEN goes to LOCKED with counters cleared.
- LOCKED: s <= {s[7:0], predicted}; the reference is free-running and not re-seeded by rx.
  - o_bit_count increments each strobe.
  - o_err_count increments when rx != predicted.
- Lock latency from enable: 9 + VERIFY_LEN strobes, i.e. (9 + VERIFY_LEN) * OS clocks at worst alignment.

Counters:
- Both counters saturate at all-ones.
- When o_bit_count saturates, both counters freeze.
- Counters clear only on reset, on IDLE to SEED, and on entering LOCKED.

o_is_zero:
- Registered; equals o_locked AND o_err_count == 0 as of the current state.

Simultaneous events:
- Reset dominates everything.
- An i_enable fall on a strobe cycle goes to IDLE and discards that strobe.

Optional Feature:
Macro RX_BER_RELOCK_EN.
- Defined: LOCKED keeps a window bit counter and a window error counter.
  - When window errors reach RELOCK_THR before RELOCK_WIN bits, the FSM goes to SEED, o_locked drops, and counters clear.
  - Both window counters reset every RELOCK_WIN bits.
- Undefined: LOCKED is held until i_enable falls or reset; no window logic is synthesised.

Test Plan:
- Reset with i_reset = 0 mid-run -> all outputs 0 within the same cycle; after release with i_enable = 0, the state stays IDLE.
- Clean stream, OS = 4, i_phase = 2, i_data = +64/-64 on phase 2 and the opposite sign on other phases, PRBS9 seed 0x1AA, enable -> o_locked rises after 25 strobes (<= 100 clocks); o_is_zero = 1; o_err_count = 0 after 1000 bits.
- Same as the clean-stream test, but flip one symbol after lock -> o_err_count = 1, o_is_zero = 0, o_bit_count continues, lock held.
- Wrong phase: i_phase = 0 with the same stimulus -> never reaches LOCKED (undefined macro) or repeated SEED entries; o_is_zero = 0.
- Error inside VERIFY at run count 10 -> returns to SEED; lock occurs 9 + 16 strobes after the error.
- With RX_BER_RELOCK_EN: inject 8 errors within 64 bits after lock -> o_locked falls, counters clear, relock after 25 clean strobes. Without the macro -> o_err_count = 8 and lock held.
